mon_fifo_flags: RTL

MON_FIFO_FLAGS -- requirements
Module: mon_fifo_flags

---
 rtl/mon_fifo_flags.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mon_fifo_flags.sv
// mon_fifo_flags: per-channel FIFO full/empty flag monitor with windowed snapshots.
// Ports: clk250_i/aresetn clock and async low reset; fifo_full_i/fifo_empty_i raw flags;
//   clear_i sync clear; status_o/status_valid_o/status_ready_i snapshot handshake;
//   full_any_o registered OR of the synchronised full flags.
module mon_fifo_flags #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int PERIOD      = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk250_i,
    input  logic                    aresetn,
    input  logic [N_CH-1:0]         fifo_full_i,
    input  logic [N_CH-1:0]         fifo_empty_i,
    input  logic                    clear_i,
    output logic [N_CH*(CNT_W+2):0] status_o,
    output logic                    status_valid_o,
    input  logic                    status_ready_i,
    output logic                    full_any_o
);

    localparam int REC_W  = CNT_W + 2;
    localparam int STAT_W = N_CH * REC_W + 1;
    localparam int WIN_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [WIN_W-1:0] TC_VAL  = WIN_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HELD  = 1'b1
    } state_t;

    logic [N_CH-1:0]   full_s;
    logic [N_CH-1:0]   empty_s;
    logic [N_CH-1:0]   full_prev;
    logic [N_CH-1:0]   full_rise;
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [N_CH-1:0]   full_seen_q;
    logic [N_CH-1:0]   empty_seen_q;
    logic              missed_q;
    logic [WIN_W-1:0]  win_q;
    logic              tc;
    logic              load;
    logic              skip;
    logic [STAT_W-1:0] snap;
    state_t            state_q;
    state_t            state_d;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign full_s  = fifo_full_i;
        assign empty_s = fifo_empty_i;
    end else begin : g_sync
        logic [N_CH-1:0] full_q  [SYNC_STAGES];
        logic [N_CH-1:0] empty_q [SYNC_STAGES];

        always_ff @(posedge clk250_i or negedge aresetn) begin
            if (!aresetn) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    full_q[i]  <= '0;
                    empty_q[i] <= '0;
                end
            end else begin
                full_q[0]  <= fifo_full_i;
                empty_q[0] <= fifo_empty_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    full_q[i]  <= full_q[i-1];
                    empty_q[i] <= empty_q[i-1];
                end
            end
        end

        assign full_s  = full_q[SYNC_STAGES-1];
        assign empty_s = empty_q[SYNC_STAGES-1];
    end

    assign full_rise = full_s & ~full_prev;
    assign tc        = (win_q == TC_VAL);

    always_ff @(posedge clk250_i or negedge aresetn) begin
        if (!aresetn) begin
            full_prev  <= '0;
            full_any_o <= 1'b0;
        end else begin
            full_prev  <= full_s;
            full_any_o <= |full_s;
        end
    end

    always_ff @(posedge clk250_i or negedge aresetn) begin
        if (!aresetn) begin
            win_q <= '0;
        end else if (clear_i || tc) begin
            win_q <= '0;
        end else begin
            win_q <= win_q + 1'b1;
        end
    end

    // A snapshot is taken at TC when the slot is free or being freed this
    // cycle; a HELD record nobody accepts turns TC into a skip instead.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        skip    = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                if (tc && !clear_i) begin
                    load    = 1'b1;
                    state_d = S_HELD;
                end
            end
            S_HELD: begin
                if (status_ready_i) begin
                    state_d = S_EMPTY;
                end
                if (tc && !clear_i) begin
                    if (status_ready_i) begin
                        load    = 1'b1;
                        state_d = S_HELD;
                    end else begin
                        skip = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk250_i or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign status_valid_o = (state_q == S_HELD);

    always_comb begin
        snap = '0;
        for (int c = 0; c < N_CH; c++) begin
            snap[c*REC_W +: REC_W] = {cnt_q[c], empty_seen_q[c], full_seen_q[c]};
        end
        snap[STAT_W-1] = missed_q;
    end

    // On a load the accumulators restart from this cycle's activity, so an
    // event seen in the TC cycle lands in the new window.
    always_ff @(posedge clk250_i or negedge aresetn) begin
        if (!aresetn) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= '0;
            end
            full_seen_q  <= '0;
            empty_seen_q <= '0;
            missed_q     <= 1'b0;
        end else if (clear_i) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= '0;
            end
            full_seen_q  <= '0;
            empty_seen_q <= '0;
            missed_q     <= 1'b0;
        end else if (load) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= CNT_W'(full_rise[c]);
            end
            full_seen_q  <= full_s;
            empty_seen_q <= empty_s;
            missed_q     <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (full_rise[c] && (cnt_q[c] != CNT_MAX)) begin
                    cnt_q[c] <= cnt_q[c] + 1'b1;
                end
            end
            full_seen_q  <= full_seen_q | full_s;
            empty_seen_q <= empty_seen_q | empty_s;
            if (skip) begin
                missed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk250_i or negedge aresetn) begin
        if (!aresetn) begin
            status_o <= '0;
        end else if (load) begin
            status_o <= snap;
        end
    end

endmodule
